uart_buffer: RTL and testbench



---
 rtl/uart_buffer_pkg.sv | 39 +++
 rtl/uart_buffer_sync_fifo.sv | 47 ++++
 rtl/uart_buffer.sv | 219 +++++++++++++++++++++
 tb/tb_uart_buffer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_buffer_pkg.sv
// Shared definitions for uart_buffer: uart register offsets, STATUS bit positions,
// CPU-side register indices and master FSM state encodings.
package uart_buffer_pkg;

   localparam logic [63:0] U_CLK_DIV_ADDR = 64'h0;
   localparam logic [63:0] U_STATUS_ADDR  = 64'h4;
   localparam logic [63:0] U_DATA_ADDR    = 64'h8;

   localparam int U_ST_TX_READY = 0;
   localparam int U_ST_RX_READY = 1;

   typedef enum logic [1:0] {
      REG_DATA    = 2'd0,
      REG_STATUS  = 2'd1,
      REG_CLK_DIV = 2'd2,
      REG_CTRL    = 2'd3
   } reg_sel_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DIV    = 3'd1,
      ST_POLL   = 3'd2,
      ST_DECIDE = 3'd3,
      ST_RXRD   = 3'd4,
      ST_TXWR   = 3'd5
   } state_e;

   // Same 16-bit lane rule the uart applies to its divider: mask[0] -> [15:0], mask[1] -> [31:16].
   function automatic logic [31:0] apply_div_lanes(input logic [31:0] old_val,
                                                    input logic [31:0] new_val,
                                                    input logic [1:0]  mask);
      logic [31:0] res;
      res = old_val;
      if (mask[0]) res[15:0]  = new_val[15:0];
      if (mask[1]) res[31:16] = new_val[31:16];
      return res;
   endfunction

endpackage

// File: rtl/uart_buffer_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is combinational, push when full and
// pop when empty are ignored.
module sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             do_push_s;
   logic             do_pop_s;

   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign count_o   = wr_ptr_q - rd_ptr_q;
   assign head_o    = mem_q[rd_ptr_q[AW-1:0]];
   assign do_push_s = push_i && !full_o;
   assign do_pop_s  = pop_i && !empty_o;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push_s) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/uart_buffer.sv
// Buffered CPU front-end for the uart register block: TX/RX FIFOs drained/filled by a
// polling master FSM. Optional CTRL register and interrupt under `UART_BUF_IRQ_EN.
module uart_buffer
   import uart_buffer_pkg::*;
#(
   parameter int TX_DEPTH = 16,
   parameter int RX_DEPTH = 16,
   parameter int DATA_W   = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] address_in,
   input  logic        sel_in,
   input  logic        read_in,
   output logic [63:0] read_value_out,
   input  logic [3:0]  write_mask_in,
   input  logic [63:0] write_value_in,
   output logic [63:0] u_address_out,
   output logic        u_sel_out,
   output logic        u_read_out,
   output logic [3:0]  u_write_mask_out,
   output logic [63:0] u_write_value_out,
   input  logic [63:0] u_read_value_in,
   output logic        irq_out
);
   localparam int TX_CW = $clog2(TX_DEPTH) + 1;
   localparam int RX_CW = $clog2(RX_DEPTH) + 1;

   state_e            state_q, state_d;
   reg_sel_e          reg_sel_s;
   logic [31:0]       div_shadow_q, div_shadow_d;
   logic              div_pending_q, div_pending_d;
   logic              rx_overflow_q, rx_overflow_d;
   logic              full_seen_q, full_seen_d;
   logic              tx_ready_q, tx_ready_d;
   logic              rx_ready_q, rx_ready_d;
   logic              tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
   logic              rx_push_s, rx_pop_s, rx_full_s, rx_empty_s;
   logic [DATA_W-1:0] tx_head_s, rx_head_s, rx_head_vis_s;
   logic [TX_CW-1:0]  tx_count_s;
   logic [RX_CW-1:0]  rx_count_s;
   logic [63:0]       ctrl_rd_s;
   logic              unused_s;

   assign reg_sel_s     = reg_sel_e'(address_in[3:2]);
   assign tx_push_s     = sel_in && write_mask_in[0] && (reg_sel_s == REG_DATA);
   assign tx_pop_s      = (state_q == ST_TXWR);
   assign rx_push_s     = (state_q == ST_RXRD) && u_read_value_in[DATA_W];
   assign rx_pop_s      = sel_in && read_in && (reg_sel_s == REG_DATA);
   assign rx_head_vis_s = rx_empty_s ? '0 : rx_head_s;
   assign unused_s      = ^{address_in[63:4], address_in[1:0], write_value_in[63:32],
                            write_mask_in[3:2], u_read_value_in[63:DATA_W+1]};

   sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(DATA_W)) u_tx_fifo (
      .clk(clk), .reset(reset), .push_i(tx_push_s), .data_i(write_value_in[DATA_W-1:0]),
      .pop_i(tx_pop_s), .head_o(tx_head_s), .full_o(tx_full_s), .empty_o(tx_empty_s),
      .count_o(tx_count_s)
   );

   sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(DATA_W)) u_rx_fifo (
      .clk(clk), .reset(reset), .push_i(rx_push_s), .data_i(u_read_value_in[DATA_W-1:0]),
      .pop_i(rx_pop_s), .head_o(rx_head_s), .full_o(rx_full_s), .empty_o(rx_empty_s),
      .count_o(rx_count_s)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = ST_IDLE;
      case (state_q)
         ST_IDLE: begin
            if (div_pending_q)               state_d = ST_DIV;
            else if (!tx_empty_s || !rx_full_s) state_d = ST_POLL;
            else                             state_d = ST_IDLE;
         end
         ST_POLL:   state_d = ST_DECIDE;
         // RX wins over TX so incoming frames are not overwritten inside the uart.
         ST_DECIDE: begin
            if (rx_ready_q && !rx_full_s)       state_d = ST_RXRD;
            else if (tx_ready_q && !tx_empty_s) state_d = ST_TXWR;
            else                                state_d = ST_IDLE;
         end
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      u_address_out     = 64'h0;
      u_sel_out         = 1'b0;
      u_read_out        = 1'b0;
      u_write_mask_out  = 4'b0000;
      u_write_value_out = 64'h0;
      if (!reset) begin
         case (state_q)
            ST_DIV: begin
               u_address_out     = U_CLK_DIV_ADDR;
               u_sel_out         = 1'b1;
               u_write_mask_out  = 4'b0011;
               u_write_value_out = {32'h0, div_shadow_q};
            end
            ST_POLL: begin
               u_address_out = U_STATUS_ADDR;
               u_sel_out     = 1'b1;
            end
            ST_RXRD: begin
               u_address_out = U_DATA_ADDR;
               u_sel_out     = 1'b1;
               u_read_out    = 1'b1;
            end
            ST_TXWR: begin
               u_address_out     = U_DATA_ADDR;
               u_sel_out         = 1'b1;
               u_write_mask_out  = 4'b0001;
               u_write_value_out = 64'(tx_head_s);
            end
            default: u_sel_out = 1'b0;
         endcase
      end else begin
         u_sel_out = 1'b0;
      end
   end

   always_comb begin
      div_shadow_d  = div_shadow_q;
      div_pending_d = div_pending_q;
      rx_overflow_d = rx_overflow_q;
      full_seen_d   = full_seen_q;
      tx_ready_d    = tx_ready_q;
      rx_ready_d    = rx_ready_q;
      if (state_q == ST_DIV) div_pending_d = 1'b0;
      else                   div_pending_d = div_pending_q;
      if (sel_in && (reg_sel_s == REG_CLK_DIV) && (write_mask_in[1:0] != 2'b00)) begin
         div_shadow_d  = apply_div_lanes(div_shadow_q, write_value_in[31:0], write_mask_in[1:0]);
         div_pending_d = 1'b1;
      end else begin
         div_shadow_d  = div_shadow_q;
      end
      if (sel_in && (reg_sel_s == REG_STATUS) && write_mask_in[0] && write_value_in[2])
         rx_overflow_d = 1'b0;
      else
         rx_overflow_d = rx_overflow_q;
      // A frame left in the uart is lost only once two polls in a row find it stuck.
      if (state_q == ST_POLL) begin
         tx_ready_d = u_read_value_in[U_ST_TX_READY];
         rx_ready_d = u_read_value_in[U_ST_RX_READY];
         if (u_read_value_in[U_ST_RX_READY] && rx_full_s) begin
            full_seen_d = 1'b1;
            if (full_seen_q) rx_overflow_d = 1'b1;
            else             rx_overflow_d = rx_overflow_d;
         end else begin
            full_seen_d = 1'b0;
         end
      end else begin
         full_seen_d = full_seen_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_shadow_q  <= 32'h0;
         div_pending_q <= 1'b0;
         rx_overflow_q <= 1'b0;
         full_seen_q   <= 1'b0;
         tx_ready_q    <= 1'b0;
         rx_ready_q    <= 1'b0;
      end else begin
         div_shadow_q  <= div_shadow_d;
         div_pending_q <= div_pending_d;
         rx_overflow_q <= rx_overflow_d;
         full_seen_q   <= full_seen_d;
         tx_ready_q    <= tx_ready_d;
         rx_ready_q    <= rx_ready_d;
      end
   end

`ifdef UART_BUF_IRQ_EN
   logic rx_ie_q, tx_ie_q, irq_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_ie_q <= 1'b0;
         tx_ie_q <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         if (sel_in && (reg_sel_s == REG_CTRL) && write_mask_in[0]) begin
            rx_ie_q <= write_value_in[0];
            tx_ie_q <= write_value_in[1];
         end
         irq_q <= (rx_ie_q & ~rx_empty_s) | (tx_ie_q & tx_empty_s);
      end
   end

   assign irq_out   = irq_q;
   assign ctrl_rd_s = {62'h0, tx_ie_q, rx_ie_q};
`else
   assign irq_out   = 1'b0;
   assign ctrl_rd_s = 64'h0;
`endif

   always_comb begin
      read_value_out = 64'h0;
      if (sel_in) begin
         case (reg_sel_s)
            REG_DATA:    read_value_out = 64'({~rx_empty_s, rx_head_vis_s});
            REG_STATUS:  read_value_out = {40'h0, 8'(rx_count_s), 8'(tx_count_s), 5'b00000,
                                           rx_overflow_q, ~rx_empty_s, ~tx_full_s};
            REG_CLK_DIV: read_value_out = {32'h0, div_shadow_q};
            REG_CTRL:    read_value_out = ctrl_rd_s;
            default:     read_value_out = 64'h0;
         endcase
      end else begin
         read_value_out = 64'h0;
      end
   end

endmodule

// File: tb/tb_uart_buffer.sv
// Directed bench for uart_buffer with a small behavioural uart model on the u_* side.
module tb_uart_buffer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] address_in = 64'h0;
   logic        sel_in = 1'b0;
   logic        read_in = 1'b0;
   logic [63:0] read_value_out;
   logic [3:0]  write_mask_in = 4'h0;
   logic [63:0] write_value_in = 64'h0;
   logic [63:0] u_address_out;
   logic        u_sel_out;
   logic        u_read_out;
   logic [3:0]  u_write_mask_out;
   logic [63:0] u_write_value_out;
   logic [63:0] u_read_value_in;
   logic        irq_out;

   // uart model state
   logic        tx_ready = 1'b0;
   logic        rx_pending = 1'b0;
   logic        rx_load = 1'b0;
   logic        rx_drop = 1'b0;
   logic        rx_hold = 1'b0;
   logic [15:0] rx_data = 16'h0;

   // monitor
   logic [63:0] tx_log[$];
   int          div_cnt = 0;
   logic [63:0] div_val = 64'h0;
   logic [3:0]  div_mask = 4'h0;
   int          rx_rd_cnt = 0;
   int          tx_bad_mask = 0;

   int checks = 0;
   int failures = 0;

   uart_buffer dut (
      .clk(clk), .reset(reset), .address_in(address_in), .sel_in(sel_in), .read_in(read_in),
      .read_value_out(read_value_out), .write_mask_in(write_mask_in),
      .write_value_in(write_value_in), .u_address_out(u_address_out), .u_sel_out(u_sel_out),
      .u_read_out(u_read_out), .u_write_mask_out(u_write_mask_out),
      .u_write_value_out(u_write_value_out), .u_read_value_in(u_read_value_in),
      .irq_out(irq_out)
   );

   always #5 clk = ~clk;

   always_comb begin
      u_read_value_in = 64'h0;
      if (u_address_out == 64'h4)      u_read_value_in = {62'h0, rx_pending, tx_ready};
      else if (u_address_out == 64'h8) u_read_value_in = {47'h0, rx_pending, rx_data};
      else                             u_read_value_in = 64'h0;
   end

   always @(posedge clk) begin
      if (rx_load)      rx_pending <= 1'b1;
      else if (rx_drop) rx_pending <= 1'b0;
      else if (!rx_hold && u_sel_out && u_read_out && u_address_out == 64'h8) rx_pending <= 1'b0;
   end

   always @(negedge clk) begin
      if (!reset && u_sel_out) begin
         if (u_write_mask_out != 4'h0) begin
            if (u_address_out == 64'h0) begin
               div_cnt  <= div_cnt + 1;
               div_val  <= u_write_value_out;
               div_mask <= u_write_mask_out;
            end else if (u_address_out == 64'h8) begin
               tx_log.push_back(u_write_value_out);
               if (u_write_mask_out != 4'b0001) tx_bad_mask <= tx_bad_mask + 1;
            end
         end else if (u_read_out && u_address_out == 64'h8) begin
            rx_rd_cnt <= rx_rd_cnt + 1;
         end
      end
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cpu_write(input logic [1:0] idx, input logic [3:0] mask, input logic [63:0] val);
      @(negedge clk);
      sel_in = 1'b1; read_in = 1'b0; address_in = {60'h0, idx, 2'b00};
      write_mask_in = mask; write_value_in = val;
      @(negedge clk);
      sel_in = 1'b0; write_mask_in = 4'h0; write_value_in = 64'h0;
   endtask

   task automatic cpu_read(input logic [1:0] idx, output logic [63:0] val);
      @(negedge clk);
      sel_in = 1'b1; read_in = 1'b1; address_in = {60'h0, idx, 2'b00}; write_mask_in = 4'h0;
      #1 val = read_value_out;
      @(negedge clk);
      sel_in = 1'b0; read_in = 1'b0;
   endtask

   task automatic pulse(input int which);
      @(negedge clk);
      if (which == 0) rx_load = 1'b1;
      else            rx_drop = 1'b1;
      @(negedge clk);
      rx_load = 1'b0; rx_drop = 1'b0;
   endtask

   initial begin
      logic [63:0] rd;
      int base;
      int rd_base;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("reset_usel", {63'h0, u_sel_out}, 64'h0);
      check_val("reset_irq", {63'h0, irq_out}, 64'h0);
      reset = 1'b0;

      cpu_read(2'd1, rd);
      check_val("status_after_reset", rd, 64'h0000_0001);
      #2 check_val("rdata_when_unselected", read_value_out, 64'h0);

      // divider write forwarded once
      cpu_write(2'd2, 4'b0011, 64'h10);
      repeat (8) @(posedge clk);
      check_val("div_count", 64'(div_cnt), 64'd1);
      check_val("div_value", div_val, 64'h10);
      check_val("div_mask", {60'h0, div_mask}, 64'h3);
      cpu_read(2'd2, rd);
      check_val("clkdiv_readback", rd, 64'h10);

      // two TX frames, in order
      tx_ready = 1'b1;
      base = tx_log.size();
      cpu_write(2'd0, 4'b0001, 64'h41);
      cpu_write(2'd0, 4'b0001, 64'h42);
      repeat (20) @(posedge clk);
      check_val("tx_two_count", 64'(tx_log.size() - base), 64'd2);
      if (tx_log.size() >= base + 2) begin
         check_val("tx_first", tx_log[base], 64'h41);
         check_val("tx_second", tx_log[base+1], 64'h42);
      end
      cpu_read(2'd1, rd);
      check_val("status_tx_drained", rd, 64'h0000_0001);

      // one RX frame
      rd_base = rx_rd_cnt;
      rx_data = 16'h1234;
      pulse(0);
      repeat (10) @(posedge clk);
      check_val("rx_one_read", 64'(rx_rd_cnt - rd_base), 64'd1);
      cpu_read(2'd1, rd);
      check_val("status_rx_one", rd, 64'h0001_0003);
      cpu_read(2'd0, rd);
      check_val("rx_pop_value", rd, 64'h1_1234);
      cpu_read(2'd0, rd);
      check_val("rx_pop_empty", rd, 64'h0);

      // TX fill to 16, 17th dropped
      tx_ready = 1'b0;
      base = tx_log.size();
      for (int i = 0; i < 16; i++) cpu_write(2'd0, 4'b0001, 64'h100 + 64'(i));
      cpu_write(2'd0, 4'b0001, 64'hFFFF);
      cpu_read(2'd1, rd);
      check_val("status_tx_full", rd, 64'h0000_1000);
      tx_ready = 1'b1;
      repeat (120) @(posedge clk);
      check_val("tx_fill_count", 64'(tx_log.size() - base), 64'd16);
      if (tx_log.size() >= base + 16) begin
         check_val("tx_fill_first", tx_log[base], 64'h100);
         check_val("tx_fill_last", tx_log[base+15], 64'h10F);
      end
      cpu_read(2'd1, rd);
      check_val("status_tx_refill_done", rd, 64'h0000_0001);

      // RX fill with frame held in uart; one TX entry keeps the poller busy
      tx_ready = 1'b0;
      cpu_write(2'd0, 4'b0001, 64'hAA);
      rd_base = rx_rd_cnt;
      rx_data = 16'h55AA;
      rx_hold = 1'b1;
      pulse(0);
      repeat (200) @(posedge clk);
      check_val("rx_fill_reads", 64'(rx_rd_cnt - rd_base), 64'd16);
      cpu_read(2'd1, rd);
      check_val("status_rx_overflow", rd, 64'h0010_0107);
      rx_hold = 1'b0;
      pulse(1);
      repeat (6) @(posedge clk);
      cpu_write(2'd1, 4'b0001, 64'h4);
      cpu_read(2'd1, rd);
      check_val("status_ovf_cleared", rd, 64'h0010_0103);
      cpu_read(2'd0, rd);
      check_val("rx_fill_first_pop", rd, 64'h1_55AA);
      for (int i = 0; i < 15; i++) cpu_read(2'd0, rd);
      cpu_read(2'd1, rd);
      check_val("status_rx_drained", rd, 64'h0000_0101);
      base = tx_log.size();
      tx_ready = 1'b1;
      repeat (20) @(posedge clk);
      check_val("tx_last_frame", 64'(tx_log.size() - base), 64'd1);
      if (tx_log.size() > base) check_val("tx_last_value", tx_log[base], 64'hAA);
      check_val("tx_mask_always_0001", 64'(tx_bad_mask), 64'd0);
      check_val("irq_tied_low", {63'h0, irq_out}, 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
